// File: rtl/nios2_system_oci_trace_pkg.sv
// Shared types, default parameters and helpers for the OCI trace capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nios2_system_oci_trace_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } trace_state_t;

   localparam int DEF_SLOT_W = 2;
   localparam int DEF_SLOTS  = 15;
   localparam int DEF_CNT_W  = 4;
   localparam int DEF_DEPTH  = 16;
   localparam int DEF_STAT_W = 16;

   // Saturating add: result never exceeds max_v. Callers cast to their counter width.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_v);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, max_v})
         return max_v;
      else
         return sum[31:0];
   endfunction

endpackage

// File: rtl/nios2_system_oci_trace_fifo.sv
// Synchronous show-ahead FIFO with registered storage, full/empty flags and occupancy count.
// Latency: a write at edge N is visible on rd_data after edge N; one pop per cycle.
// Backpressure: caller must not write when full unless reading in the same cycle; clr empties it.
module nios2_system_oci_trace_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Storage needs no reset: only entries behind the write pointer are ever read.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!reset_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_en)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/nios2_system_oci_trace_capture.sv
// Captures packed data-trace frames into a FIFO and drains them on a valid/ready stream, with end-of-test flush.
// Latency: frame accepted at edge N is presented on out_* after edge N; marker frame the cycle after flush entry.
// Backpressure: out_ready low holds the head frame; pushes into a full FIFO without a pop are dropped and counted.
// Optional build macro OCI_TRACE_TSTAMP_EN adds a per-entry cycle timestamp on out_tstamp.
module nios2_system_oci_trace_capture
   import nios2_system_oci_trace_pkg::*;
#(
   parameter int SLOT_W = DEF_SLOT_W,
   parameter int SLOTS  = DEF_SLOTS,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int STAT_W = DEF_STAT_W
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [SLOTS*SLOT_W-1:0]   dct_buffer,
   input  logic [CNT_W-1:0]          dct_count,
   input  logic                      dct_valid,
   input  logic                      test_ending,
   input  logic                      test_has_ended,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SLOTS*SLOT_W-1:0]   out_data,
   output logic [CNT_W-1:0]          out_count,
   output logic                      out_last,
   output logic [STAT_W-1:0]         frame_cnt,
   output logic [STAT_W-1:0]         slot_cnt,
   output logic [STAT_W-1:0]         drop_cnt,
   output logic                      overflow,
   output logic                      done
`ifdef OCI_TRACE_TSTAMP_EN
   ,output logic [STAT_W-1:0]        out_tstamp
`endif
);

   localparam int BUF_W = SLOTS * SLOT_W;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef OCI_TRACE_TSTAMP_EN
   localparam int FW    = BUF_W + CNT_W + STAT_W;
`else
   localparam int FW    = BUF_W + CNT_W;
`endif
   localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF >> (32 - STAT_W);

   trace_state_t      state;
   logic [CNT_W-1:0]  clamp_cnt;
   logic              push_req, push, drop, pop, head_ok;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [FW-1:0]     wr_data, rd_data;

   // Oversized slot counts are limited to the physical slot count.
   always_comb begin
      clamp_cnt = dct_count;
      if (32'(dct_count) > 32'(SLOTS))
         clamp_cnt = CNT_W'(SLOTS);
   end

   // Only RUN accepts frames; an abort in the same cycle wins since the FIFO is discarded anyway.
   assign push_req = (state == ST_RUN) && dct_valid && (dct_count != '0) && !test_has_ended;
   assign pop      = out_valid && out_ready;
   assign push     = push_req && (!fifo_full || pop);
   assign drop     = push_req && fifo_full && !pop;

`ifdef OCI_TRACE_TSTAMP_EN
   logic [STAT_W-1:0] tstamp_ctr;
   logic [STAT_W-1:0] flush_ts;

   // Free-running cycle counter; its value at flush entry is kept for the marker frame.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tstamp_ctr <= '0;
         flush_ts   <= '0;
      end else begin
         tstamp_ctr <= tstamp_ctr + 1'b1;
         if (state == ST_RUN && test_ending && !test_has_ended)
            flush_ts <= tstamp_ctr;
      end
   end

   assign wr_data = {tstamp_ctr, clamp_cnt, dct_buffer};
`else
   assign wr_data = {clamp_cnt, dct_buffer};
`endif

   nios2_system_oci_trace_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (test_has_ended),
      .wr_en   (push),
      .wr_data (wr_data),
      .rd_en   (pop && !fifo_empty),
      .rd_data (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // In FLUSH an empty FIFO means the marker frame is pending, so FLUSH always presents a frame.
   always_comb begin
      head_ok   = !fifo_empty && (state != ST_DONE);
      out_valid = (state == ST_FLUSH) || ((state == ST_RUN) && !fifo_empty);
      out_data  = head_ok ? rd_data[BUF_W-1:0] : '0;
      out_count = head_ok ? rd_data[BUF_W +: CNT_W] : '0;
      out_last  = (state == ST_FLUSH) && (fifo_empty || fifo_count == CW'(1));
      done      = (state == ST_DONE);
`ifdef OCI_TRACE_TSTAMP_EN
      out_tstamp = head_ok ? rd_data[BUF_W+CNT_W +: STAT_W]
                           : ((state == ST_FLUSH) ? flush_ts : '0);
`endif
   end

   // End-of-test sequencing; abort takes priority over the orderly flush.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_RUN;
      end else if (test_has_ended) begin
         state <= ST_DONE;
      end else begin
         unique case (state)
            ST_RUN:   if (test_ending) state <= ST_FLUSH;
            ST_FLUSH: if (pop && out_last) state <= ST_DONE;
            default:  state <= ST_DONE;
         endcase
      end
   end

   // Statistics move only on accepted or dropped pushes, which cannot happen outside RUN.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_cnt <= '0;
         slot_cnt  <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push) begin
            frame_cnt <= STAT_W'(sat_add(32'(frame_cnt), 32'd1, STAT_MAX));
            slot_cnt  <= STAT_W'(sat_add(32'(slot_cnt), 32'(clamp_cnt), STAT_MAX));
         end
         if (drop) begin
            drop_cnt <= STAT_W'(sat_add(32'(drop_cnt), 32'd1, STAT_MAX));
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nios2_system_oci_trace_capture.sv
// Bench for the OCI trace capture block: queue-based reference model checked every cycle,
// plus literal expectations per scenario. A second instance with 4-bit statistics shares
// the stimulus to exercise counter saturation.
module tb_nios2_system_oci_trace_capture;

   localparam int SLOT_W = 2;
   localparam int SLOTS  = 15;
   localparam int CNT_W  = 4;
   localparam int DEPTH  = 16;
   localparam int BW     = SLOTS * SLOT_W;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [BW-1:0]     dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic              dct_valid, test_ending, test_has_ended, out_ready;

   logic              out_valid, out_last, overflow, done;
   logic [BW-1:0]     out_data;
   logic [CNT_W-1:0]  out_count;
   logic [15:0]       frame_cnt, slot_cnt, drop_cnt;

   logic              b_out_valid, b_out_last, b_overflow, b_done;
   logic [BW-1:0]     b_out_data;
   logic [CNT_W-1:0]  b_out_count;
   logic [3:0]        b_frame_cnt, b_slot_cnt, b_drop_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   nios2_system_oci_trace_capture #(
      .SLOT_W(SLOT_W), .SLOTS(SLOTS), .CNT_W(CNT_W), .DEPTH(DEPTH), .STAT_W(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_last(out_last), .frame_cnt(frame_cnt),
      .slot_cnt(slot_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .done(done)
   );

   nios2_system_oci_trace_capture #(
      .SLOT_W(SLOT_W), .SLOTS(SLOTS), .CNT_W(CNT_W), .DEPTH(DEPTH), .STAT_W(4)
   ) dut_sat (
      .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .out_count(b_out_count), .out_last(b_out_last), .frame_cnt(b_frame_cnt),
      .slot_cnt(b_slot_cnt), .drop_cnt(b_drop_cnt), .overflow(b_overflow), .done(b_done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_state: 0 = accepting, 1 = flushing, 2 = finished
   int                   m_state = 0;
   logic [BW+CNT_W-1:0]  mq[$];
   longint               tot_f = 0, tot_s = 0, tot_d = 0;
   bit                   m_ovf = 1'b0;

   function automatic longint satv(input longint v, input longint mx);
      return (v > mx) ? mx : v;
   endfunction

   // Compare on the falling edge, then advance the model with the inputs the next edge will see.
   initial begin : compare_proc
      bit                  ev, el, pop;
      logic [BW+CNT_W-1:0] head;
      int                  c;
      @(posedge clk);
      forever begin
         @(negedge clk);
         ev   = (m_state == 0 && mq.size() > 0) || (m_state == 1);
         head = (m_state != 2 && mq.size() > 0) ? mq[0] : '0;
         el   = (m_state == 1) && (mq.size() <= 1);
         chk("out_valid", out_valid, ev);
         chk("out_data", out_data, head[BW-1:0]);
         chk("out_count", out_count, head[BW +: CNT_W]);
         chk("out_last", out_last, el);
         chk("done", done, m_state == 2);
         chk("overflow", overflow, m_ovf);
         chk("frame_cnt", frame_cnt, satv(tot_f, 65535));
         chk("slot_cnt", slot_cnt, satv(tot_s, 65535));
         chk("drop_cnt", drop_cnt, satv(tot_d, 65535));
         chk("sat_frame_cnt", b_frame_cnt, satv(tot_f, 15));
         chk("sat_slot_cnt", b_slot_cnt, satv(tot_s, 15));
         chk("sat_drop_cnt", b_drop_cnt, satv(tot_d, 15));
         chk("sat_out_valid", b_out_valid, ev);
         if (!reset_n) begin
            m_state = 0; mq.delete(); tot_f = 0; tot_s = 0; tot_d = 0; m_ovf = 1'b0;
         end else begin
            pop = ev && out_ready;
            if (test_has_ended) begin
               m_state = 2;
               mq.delete();
            end else if (m_state == 0) begin
               if (pop) void'(mq.pop_front());
               if (dct_valid && dct_count != 0) begin
                  c = (int'(dct_count) > SLOTS) ? SLOTS : int'(dct_count);
                  if (mq.size() < DEPTH) begin
                     mq.push_back({CNT_W'(c), dct_buffer});
                     tot_f += 1;
                     tot_s += c;
                  end else begin
                     tot_d += 1;
                     m_ovf = 1'b1;
                  end
               end
               if (test_ending) m_state = 1;
            end else if (m_state == 1) begin
               if (pop) begin
                  if (el) m_state = 2;
                  if (mq.size() > 0) void'(mq.pop_front());
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      dct_valid = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
   endtask

   task automatic do_reset();
      quiet();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic push(input logic [BW-1:0] d, input logic [CNT_W-1:0] c);
      dct_buffer = d;
      dct_count  = c;
      dct_valid  = 1'b1;
      step();
      dct_valid  = 1'b0;
   endtask

   initial begin : main_proc
      reset_n = 1'b0; dct_buffer = '0; dct_count = '0; out_ready = 1'b0;
      quiet();

      // Reset state
      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_done", done, 0);
      chk("rst_overflow", overflow, 0);

      // Three frames streamed straight through
      out_ready = 1'b1;
      push(30'h3FFF_FFFF, 4'd15);
      push(30'h0123_4567, 4'd7);
      push(30'h0000_0003, 4'd1);
      step(); step();
      chk("t1_frame_cnt", frame_cnt, 3);
      chk("t1_slot_cnt", slot_cnt, 23);
      chk("t1_sat_slot_cnt", b_slot_cnt, 15);
      chk("t1_sat_frame_cnt", b_frame_cnt, 3);

      // Overflow: 20 pushes into a 16-deep FIFO with the sink stalled
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++)
         push(BW'(i * 37 + 5), CNT_W'(i % 15 + 1));
      chk("t2_drop_cnt", drop_cnt, 4);
      chk("t2_overflow", overflow, 1);
      chk("t2_frame_cnt", frame_cnt, 16);
      chk("t2_slot_cnt", slot_cnt, 121);
      chk("t2_sat_frame_cnt", b_frame_cnt, 15);
      // Push and pop in the same full cycle
      out_ready = 1'b1;
      push(30'h155, 4'd3);
      chk("t2_pp_drop_cnt", drop_cnt, 4);
      chk("t2_pp_frame_cnt", frame_cnt, 17);
      repeat (20) step();

      // Zero-count frame is ignored
      do_reset();
      out_ready = 1'b1;
      push(30'h0AA, 4'd0);
      push(30'h02A, 4'd15);
      step();
      chk("t3_frame_cnt", frame_cnt, 1);
      chk("t3_slot_cnt", slot_cnt, 15);

      // Orderly flush of two queued frames
      do_reset();
      out_ready = 1'b0;
      push(30'h1111, 4'd2);
      push(30'h2222, 4'd3);
      test_ending = 1'b1;
      step();
      test_ending = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 10 && !done; k++) step();
      chk("t4_done", done, 1);
      push(30'h3333, 4'd5);
      step();
      chk("t4_late_frame_cnt", frame_cnt, 2);
      chk("t4_late_out_valid", out_valid, 0);

      // Flush with an empty FIFO produces a marker frame
      do_reset();
      out_ready = 1'b0;
      test_ending = 1'b1;
      step();
      test_ending = 1'b0;
      chk("t5_marker_valid", out_valid, 1);
      chk("t5_marker_count", out_count, 0);
      chk("t5_marker_last", out_last, 1);
      step();
      out_ready = 1'b1;
      step();
      chk("t5_done", done, 1);
      chk("t5_done_out_valid", out_valid, 0);

      // Abort with five queued frames
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push(BW'(i + 100), 4'd4);
      test_has_ended = 1'b1;
      step();
      test_has_ended = 1'b0;
      chk("t6_done", done, 1);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_frame_cnt", frame_cnt, 5);

      // Reset while flushing
      do_reset();
      out_ready = 1'b0;
      push(30'h10, 4'd1);
      push(30'h20, 4'd2);
      push(30'h30, 4'd3);
      test_ending = 1'b1;
      step();
      test_ending = 1'b0;
      step();
      reset_n = 1'b0;
      step();
      chk("t7_out_valid", out_valid, 0);
      chk("t7_out_last", out_last, 0);
      chk("t7_done", done, 0);
      chk("t7_frame_cnt", frame_cnt, 0);
      chk("t7_out_count", out_count, 0);
      reset_n = 1'b1;
      out_ready = 1'b1;
      push(30'h77, 4'd6);
      step(); step();
      chk("t7_after_frame_cnt", frame_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
